// File: rtl/ex_pipe_ctrl_if.sv
// ============================================================================
// Module      : ex_pipe_ctrl_if
// Description : Hazard/redirect control bundle between the pipeline datapath
//               and the EX-stage pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_pipe_ctrl_if;
    logic        id_valid;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd_addr;
    logic        ex_mem_read;
    logic        ex_branch_sel;
    logic [1:0]  ex_jump;
    logic [31:0] ex_branch_target;
    logic [31:0] ex_jump_target;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_sel;
    logic [31:0] pc_redirect;
    logic        stall_if;
    logic        stall_id;
    logic        stall_ex;
    logic        flush_id;
    logic        flush_ex;
    logic        ex_valid;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cnt;
    logic [15:0] redirect_cnt;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        output ex_rd_addr, ex_mem_read, ex_branch_sel, ex_jump,
        output ex_branch_target, ex_jump_target, mem_req, mem_ready,
        input  pc_sel, pc_redirect, stall_if, stall_id, stall_ex,
        input  flush_id, flush_ex, ex_valid, ctrl_state, stall_cnt, redirect_cnt
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        input  ex_rd_addr, ex_mem_read, ex_branch_sel, ex_jump,
        input  ex_branch_target, ex_jump_target, mem_req, mem_ready,
        output pc_sel, pc_redirect, stall_if, stall_id, stall_ex,
        output flush_id, flush_ex, ex_valid, ctrl_state, stall_cnt, redirect_cnt
    );
endinterface

`default_nettype wire

// File: rtl/ex_pipe_ctrl.sv
// ============================================================================
// Module      : ex_pipe_ctrl
// Description : EX-stage pipeline controller: memory freeze, branch/jump
//               redirect and load-use bubble arbitration with event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_pipe_ctrl (
    input  wire logic       clk,
    input  wire logic       rst_n,
    ex_pipe_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_FREEZE = 2'b01,
        ST_REDIR  = 2'b10,
        ST_BUBBLE = 2'b11
    } state_t;

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_ex_valid;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_redirect_cnt;

    logic        w_freeze;
    logic        w_jump;
    logic        w_redir;
    logic        w_hit_rs1;
    logic        w_hit_rs2;
    logic        w_luh;
    logic        w_pc_sel;
    logic [31:0] w_pc_redirect;
    logic        w_stall_if;
    logic        w_stall_id;
    logic        w_stall_ex;
    logic        w_flush_id;
    logic        w_flush_ex;

    assign w_freeze  = bus.mem_req & ~bus.mem_ready;
    // Encoding 11 is reserved and behaves as "no jump".
    assign w_jump    = (bus.ex_jump == 2'b01) | (bus.ex_jump == 2'b10);
    assign w_redir   = r_ex_valid & (bus.ex_branch_sel | w_jump);
    assign w_hit_rs1 = bus.id_uses_rs1 & (bus.id_rs1_addr == bus.ex_rd_addr);
    assign w_hit_rs2 = bus.id_uses_rs2 & (bus.id_rs2_addr == bus.ex_rd_addr);
    assign w_luh     = r_ex_valid & bus.ex_mem_read & bus.id_valid &
                       (bus.ex_rd_addr != 5'd0) & (w_hit_rs1 | w_hit_rs2);

    always_comb begin
        w_next_state  = ST_RUN;
        w_pc_sel      = 1'b0;
        w_pc_redirect = 32'd0;
        w_stall_if    = 1'b0;
        w_stall_id    = 1'b0;
        w_stall_ex    = 1'b0;
        w_flush_id    = 1'b0;
        w_flush_ex    = 1'b0;
        if (w_freeze) begin
            // Redirect/bubble stay pending: EX state is held, so they re-evaluate later.
            w_next_state = ST_FREEZE;
            w_stall_if   = 1'b1;
            w_stall_id   = 1'b1;
            w_stall_ex   = 1'b1;
        end else if (w_redir) begin
            w_next_state  = ST_REDIR;
            w_pc_sel      = 1'b1;
            w_pc_redirect = w_jump ? bus.ex_jump_target : bus.ex_branch_target;
            w_flush_id    = 1'b1;
            w_flush_ex    = 1'b1;
        end else if (w_luh) begin
            w_next_state = ST_BUBBLE;
            w_stall_if   = 1'b1;
            w_stall_id   = 1'b1;
            w_flush_ex   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_ex_valid     <= 1'b0;
            r_stall_cnt    <= 16'd0;
            r_redirect_cnt <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if (!w_freeze) begin
                r_ex_valid <= bus.id_valid & ~(w_redir | w_luh);
            end
            if (((w_next_state == ST_FREEZE) || (w_next_state == ST_BUBBLE)) &&
                (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if ((w_next_state == ST_REDIR) && (r_redirect_cnt != c_CNT_MAX)) begin
                r_redirect_cnt <= r_redirect_cnt + 16'd1;
            end
        end
    end

    assign bus.pc_sel       = w_pc_sel;
    assign bus.pc_redirect  = w_pc_redirect;
    assign bus.stall_if     = w_stall_if;
    assign bus.stall_id     = w_stall_id;
    assign bus.stall_ex     = w_stall_ex;
    assign bus.flush_id     = w_flush_id;
    assign bus.flush_ex     = w_flush_ex;
    assign bus.ex_valid     = r_ex_valid;
    assign bus.ctrl_state   = r_state;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.redirect_cnt = r_redirect_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ex_pipe_ctrl.sv
// ============================================================================
// Module      : tb_ex_pipe_ctrl
// Description : Scoreboard bench for ex_pipe_ctrl; expected observations are
//               queued as stimulus is driven and compared at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_pipe_ctrl;

    typedef struct packed {
        logic        rst_n;
        logic        id_valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        mrd;
        logic        bsel;
        logic [1:0]  jump;
        logic [31:0] btgt;
        logic [31:0] jtgt;
        logic        mreq;
        logic        mrdy;
    } in_t;

    // ctl bits: pc_sel, flush_id, flush_ex, stall_if, stall_id, stall_ex, ex_valid
    typedef struct packed {
        logic [6:0]  ctl;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] rc;
        logic [31:0] pcr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t q[$];
    exp_t obs;

    ex_pipe_ctrl_if pb ();

    ex_pipe_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pb.slave)
    );

    assign obs = {pb.pc_sel, pb.flush_id, pb.flush_ex, pb.stall_if, pb.stall_id,
                  pb.stall_ex, pb.ex_valid, pb.ctrl_state, pb.stall_cnt,
                  pb.redirect_cnt, pb.pc_redirect};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic exp_t mk(input logic [6:0] ctl, input logic [1:0] st,
                                input logic [15:0] sc, input logic [15:0] rc,
                                input logic [31:0] pcr);
        return {ctl, st, sc, rc, pcr};
    endfunction

    function automatic in_t idle();
        in_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    task automatic drive(input in_t s);
        rst_n               = s.rst_n;
        pb.id_valid         = s.id_valid;
        pb.id_rs1_addr      = s.rs1;
        pb.id_rs2_addr      = s.rs2;
        pb.id_uses_rs1      = s.u1;
        pb.id_uses_rs2      = s.u2;
        pb.ex_rd_addr       = s.rd;
        pb.ex_mem_read      = s.mrd;
        pb.ex_branch_sel    = s.bsel;
        pb.ex_jump          = s.jump;
        pb.ex_branch_target = s.btgt;
        pb.ex_jump_target   = s.jtgt;
        pb.mem_req          = s.mreq;
        pb.mem_ready        = s.mrdy;
    endtask

    task automatic test_reset();
        in_t s;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            s = idle();
            e = '0;
            case (i)
                0, 1: begin
                    s.rst_n = 1'b0; s.id_valid = 1'b1; s.mreq = 1'b1;
                    e = mk(7'b0001110, 2'b00, 16'd0, 16'd0, 32'd0);
                end
                2: s.id_valid = 1'b1;
                3: begin
                    s.id_valid = 1'b1; s.bsel = 1'b1; s.btgt = 32'h44;
                    e = mk(7'b1110001, 2'b00, 16'd0, 16'd0, 32'h44);
                end
                default: ;
            endcase
            drive(s);
            q.push_back(e);
            @(negedge clk);
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL reset_q cyc=%0d got=empty_queue required=entry", i);
            end else begin
                e = q.pop_front();
                if (obs !== e) begin
                    failures++;
                    $display("FAIL reset cyc=%0d got=%h required=%h", i, obs, e);
                end
            end
            if (i == 3) begin
                // Asynchronous reset mid-redirect drops the redirect immediately.
                #1 rst_n = 1'b0;
                q.push_back(mk(7'b0000000, 2'b00, 16'd0, 16'd0, 32'd0));
                #1;
                checks++;
                e = q.pop_front();
                if (obs !== e) begin
                    failures++;
                    $display("FAIL reset_async_redir got=%h required=%h", obs, e);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        in_t s;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            s = idle();
            e = '0;
            case (i)
                0: s.rst_n = 1'b0;
                1: s.id_valid = 1'b1;
                2: begin
                    s.id_valid = 1'b1; s.bsel = 1'b1; s.btgt = 32'h100;
                    e = mk(7'b1110001, 2'b00, 16'd0, 16'd0, 32'h100);
                end
                default: e = mk(7'b0000000, 2'b10, 16'd0, 16'd1, 32'd0);
            endcase
            drive(s);
            q.push_back(e);
            @(negedge clk);
            checks++;
            e = q.pop_front();
            if (obs !== e) begin
                failures++;
                $display("FAIL branch cyc=%0d got=%h required=%h", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_jump();
        in_t s;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            s = idle();
            e = '0;
            case (i)
                0: s.rst_n = 1'b0;
                1: s.id_valid = 1'b1;
                2: begin
                    s.jump = 2'b01; s.bsel = 1'b1; s.jtgt = 32'h204; s.btgt = 32'h100;
                    e = mk(7'b1110001, 2'b00, 16'd0, 16'd0, 32'h204);
                end
                3: begin
                    s.id_valid = 1'b1;
                    e = mk(7'b0000000, 2'b10, 16'd0, 16'd1, 32'd0);
                end
                4: begin
                    s.id_valid = 1'b1; s.jump = 2'b10; s.jtgt = 32'h300; s.btgt = 32'h500;
                    e = mk(7'b1110001, 2'b00, 16'd0, 16'd1, 32'h300);
                end
                5: begin
                    s.id_valid = 1'b1;
                    e = mk(7'b0000000, 2'b10, 16'd0, 16'd2, 32'd0);
                end
                default: begin
                    s.jump = 2'b11; s.jtgt = 32'h400; s.btgt = 32'h600;
                    e = mk(7'b0000001, 2'b00, 16'd0, 16'd2, 32'd0);
                end
            endcase
            drive(s);
            q.push_back(e);
            @(negedge clk);
            checks++;
            e = q.pop_front();
            if (obs !== e) begin
                failures++;
                $display("FAIL jump cyc=%0d got=%h required=%h", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        in_t s;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            s = idle();
            e = '0;
            case (i)
                0: s.rst_n = 1'b0;
                1: s.id_valid = 1'b1;
                2, 3: begin
                    s.id_valid = 1'b1; s.mrd = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
                    e = (i == 2) ? mk(7'b0011101, 2'b00, 16'd0, 16'd0, 32'd0)
                                 : mk(7'b0000000, 2'b11, 16'd1, 16'd0, 32'd0);
                end
                4: begin
                    s.id_valid = 1'b1; s.mrd = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b1;
                    e = mk(7'b0011101, 2'b00, 16'd1, 16'd0, 32'd0);
                end
                default: e = mk(7'b0000000, 2'b11, 16'd2, 16'd0, 32'd0);
            endcase
            drive(s);
            q.push_back(e);
            @(negedge clk);
            checks++;
            e = q.pop_front();
            if (obs !== e) begin
                failures++;
                $display("FAIL load_use cyc=%0d got=%h required=%h", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_no_hazard();
        in_t s;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            s = idle();
            e = '0;
            case (i)
                0: s.rst_n = 1'b0;
                1: s.id_valid = 1'b1;
                2: begin
                    s.id_valid = 1'b1; s.mrd = 1'b1; s.rd = 5'd0;
                    s.rs1 = 5'd0; s.rs2 = 5'd0; s.u1 = 1'b1; s.u2 = 1'b1;
                    e = mk(7'b0000001, 2'b00, 16'd0, 16'd0, 32'd0);
                end
                3: begin
                    s.id_valid = 1'b1; s.mrd = 1'b1; s.rd = 5'd3;
                    s.rs1 = 5'd3; s.u1 = 1'b0; s.rs2 = 5'd4; s.u2 = 1'b1;
                    e = mk(7'b0000001, 2'b00, 16'd0, 16'd0, 32'd0);
                end
                default: e = mk(7'b0000001, 2'b00, 16'd0, 16'd0, 32'd0);
            endcase
            drive(s);
            q.push_back(e);
            @(negedge clk);
            checks++;
            e = q.pop_front();
            if (obs !== e) begin
                failures++;
                $display("FAIL no_hazard cyc=%0d got=%h required=%h", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_freeze_redir();
        in_t s;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            s = idle();
            e = '0;
            case (i)
                0: s.rst_n = 1'b0;
                1: s.id_valid = 1'b1;
                2, 3, 4: begin
                    s.id_valid = 1'b1; s.bsel = 1'b1; s.btgt = 32'h80; s.mreq = 1'b1;
                    e = mk(7'b0001111, (i == 2) ? 2'b00 : 2'b01, 16'(i - 2), 16'd0, 32'd0);
                end
                5: begin
                    s.id_valid = 1'b1; s.bsel = 1'b1; s.btgt = 32'h80;
                    s.mreq = 1'b1; s.mrdy = 1'b1;
                    e = mk(7'b1110001, 2'b01, 16'd3, 16'd0, 32'h80);
                end
                default: e = mk(7'b0000000, 2'b10, 16'd3, 16'd1, 32'd0);
            endcase
            drive(s);
            q.push_back(e);
            @(negedge clk);
            checks++;
            e = q.pop_front();
            if (obs !== e) begin
                failures++;
                $display("FAIL freeze_redir cyc=%0d got=%h required=%h", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_saturation();
        in_t s;
        exp_t e;
        int k;
        for (int i = 0; i < 65540; i++) begin
            s = idle();
            e = '0;
            if (i == 0) begin
                s.rst_n = 1'b0;
            end else if (i == 1) begin
                s.id_valid = 1'b1;
            end else begin
                k = i - 2;
                s.mreq = 1'b1;
                e = mk(7'b0001111, (k == 0) ? 2'b00 : 2'b01,
                       (k > 65535) ? 16'hFFFF : 16'(k), 16'd0, 32'd0);
            end
            drive(s);
            q.push_back(e);
            @(negedge clk);
            checks++;
            e = q.pop_front();
            if (obs !== e) begin
                failures++;
                $display("FAIL saturation cyc=%0d got=%h required=%h", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
        // Reset pulse mid-freeze: registers clear at once, freeze stalls remain.
        #2 rst_n = 1'b0;
        q.push_back(mk(7'b0001110, 2'b00, 16'd0, 16'd0, 32'd0));
        #1;
        checks++;
        e = q.pop_front();
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_mid_freeze got=%h required=%h", obs, e);
        end
        @(posedge clk);
        #1;
        s = idle();
        s.id_valid = 1'b1;
        drive(s);
        @(posedge clk);
        #1;
        drive(idle());
        q.push_back(mk(7'b0000001, 2'b00, 16'd0, 16'd0, 32'd0));
        @(negedge clk);
        checks++;
        e = q.pop_front();
        if (obs !== e) begin
            failures++;
            $display("FAIL first_edge_after_reset got=%h required=%h", obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(idle());
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_branch();
        test_jump();
        test_load_use();
        test_no_hazard();
        test_freeze_redir();
        test_saturation();
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_pipe_ctrl.md
EX_PIPE_CTRL -- requirements
Module: ex_pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Ports SHALL be as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rs1_addr, id_rs2_addr  in  5 each  ID source register indices.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction reads rs1 / rs2.
- ex_rd_addr  in  5  EX destination register index.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_branch_sel  in  1  branch comparator result for the EX instruction.
- ex_jump  in  2  00 none, 01 JALR, 10 JAL, 11 reserved (treated as none).
- ex_branch_target, ex_jump_target  in  32 each  EX-computed targets.
- mem_req  in  1  the MEM stage has an outstanding data access.
- mem_ready  in  1  data memory completes the MEM access this cycle.
- pc_sel  out  1  IF takes pc_redirect.
- pc_redirect  out  32  next-PC override.
- stall_if, stall_id, stall_ex  out  1 each  hold the IF/ID/EX pipeline registers.
- flush_id  out  1  IF/ID register loads a bubble.
- flush_ex  out  1  ID/EX register loads a bubble.
- ex_valid  out  1  the EX stage holds a live instruction.
- ctrl_state  out  2  registered FSM state.
- stall_cnt  out  16  stall cycle counter.
- redirect_cnt  out  16  redirect counter.

Function
REQ-002 freeze SHALL be mem_req AND NOT mem_ready.
REQ-003 redir SHALL be ex_valid AND (ex_branch_sel OR ex_jump==01 OR ex_jump==10).
REQ-004 luh (load-use hazard) SHALL be asserted when all of the following hold:
- ex_valid, ex_mem_read and id_valid are 1;
- ex_rd_addr is not 0;
- (id_uses_rs1 AND id_rs1_addr==ex_rd_addr) OR (id_uses_rs2 AND id_rs2_addr==ex_rd_addr).
REQ-005 Priority SHALL be freeze > redir > luh > run, evaluated combinationally in the same cycle.
REQ-006 On freeze:
- stall_if, stall_id and stall_ex SHALL be 1;
- pc_sel, flush_id and flush_ex SHALL be 0.
- A pending redir or luh SHALL be deferred, not dropped.
REQ-007 On redir:
- pc_sel, flush_id and flush_ex SHALL be 1;
- all stalls SHALL be 0.
REQ-008 pc_redirect SHALL equal ex_jump_target when ex_jump is 01 or 10, else ex_branch_target. Jump SHALL win over branch_sel when both are set.
REQ-009 pc_redirect SHALL be 0 whenever pc_sel is 0.
REQ-010 On luh: stall_if=1, stall_id=1, flush_ex=1; stall_ex=0, flush_id=0, pc_sel=0.
REQ-011 On run: all control outputs SHALL be 0.
REQ-012 The ex_valid register SHALL update as follows:
- hold its value on freeze;
- otherwise load id_valid AND NOT (redir OR luh).
REQ-013 ctrl_state SHALL register the action taken in the current cycle (RUN=00, FREEZE=01, REDIR=10, BUBBLE=11) and be visible the next cycle.
REQ-014 Because REQ-012 forces ex_valid=0 after REDIR or BUBBLE, neither redir nor luh SHALL be asserted in the cycle following REDIR or BUBBLE.
REQ-015 stall_cnt SHALL increment by 1 on each freeze or luh cycle and saturate at 16'hFFFF.
REQ-016 redirect_cnt SHALL increment by 1 on each redir cycle and saturate at 16'hFFFF.
REQ-017 All control outputs SHALL be combinational from current inputs and registered state, with zero-cycle latency; counter and ctrl_state updates SHALL have one-cycle latency.
REQ-018 ex_rd_addr==0 SHALL never produce luh, including for loads to x0.

Reset
REQ-019 While rst_n=0, the following SHALL be reset regardless of clk:
- ex_valid=0;
- ctrl_state=00;
- stall_cnt=0;
- redirect_cnt=0.
REQ-020 During reset, combinational outputs SHALL follow from ex_valid=0: pc_sel=0, flush_id=0, flush_ex=0 and pc_redirect=0. stall_if, stall_id and stall_ex SHALL be 0 unless freeze is asserted.
REQ-021 Reset asserted mid-freeze or mid-redirect SHALL discard the pending action. After rst_n deasserts, the first edge SHALL load ex_valid from id_valid.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- ex_valid=1, ex_branch_sel=1, ex_branch_target=0x100 -> same cycle: pc_sel=1, pc_redirect=0x100, flush_id=1, flush_ex=1; next cycle: ctrl_state=10, ex_valid=0, redirect_cnt=1.
- ex_valid=1, ex_jump=01, ex_branch_sel=1, ex_jump_target=0x204 -> pc_redirect=0x204.
- ex load with rd=5, id_rs2_addr=5, id_uses_rs2=1 -> one cycle with stall_if=1, stall_id=1, flush_ex=1; next cycle: ctrl_state=11, ex_valid=0, no second stall, stall_cnt=1.
- Same load with rd=0 -> no stall; ctrl_state stays 00.
- mem_req=1, mem_ready=0 for 3 cycles while redir is pending -> all three stalls high and pc_sel=0 for 3 cycles; redirect issues on the 4th cycle; stall_cnt=3.
- Preload stall_cnt to 0xFFFE, then 3 freeze cycles -> stall_cnt=0xFFFF and holds; rst_n pulse mid-freeze -> all registered outputs 0 immediately.
